sram_seq_streamer: RTL and testbench

- Controller that sits on the far side of the single-port sequence SRAM (CLKA/CENA/WENA/AA/DA/QA, active-low enables, 1-cycle registered read).
- Accepts a valid/ready word stream and writes it into SRAM words 0..len-1.
- On request, reads those words back and streams them to the PE-array feeder through a valid/ready output with backpressure.
- Hides the SRAM read latency at full throughput.

---
 rtl/sram_seq_streamer_pkg.sv | 16 +
 rtl/seq_stream_fifo.sv | 65 ++++++
 rtl/sram_seq_streamer.sv | 170 +++++++++++++++++
 tb/tb_sram_seq_streamer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_streamer_pkg.sv
// Shared constants and state encoding for the sequence SRAM streamer.
package sram_seq_streamer_pkg;

  localparam int unsigned WORD_WIDTH_DEF = 128;
  localparam int unsigned ADDR_WIDTH_DEF = 11;
  localparam int unsigned SEQ_FIFO_DEPTH = 4;
  localparam int unsigned SEQ_FIFO_CNT_W = $clog2(SEQ_FIFO_DEPTH + 1);
  localparam int unsigned SEQ_FIFO_PTR_W = $clog2(SEQ_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } state_e;

endpackage

// File: rtl/seq_stream_fifo.sv
// Small skid FIFO that absorbs SRAM read data while the consumer stalls.
module seq_stream_fifo
  import sram_seq_streamer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [WORD_WIDTH-1:0]     i_data,
  input  logic                      i_pop,
  output logic [WORD_WIDTH-1:0]     o_head,
  output logic [SEQ_FIFO_CNT_W-1:0] o_count,
  output logic                      o_empty,
  output logic                      o_full
);

  logic [WORD_WIDTH-1:0]     mem_q [SEQ_FIFO_DEPTH];
  logic [WORD_WIDTH-1:0]     mem_d [SEQ_FIFO_DEPTH];
  logic [SEQ_FIFO_PTR_W-1:0] wp_q, wp_d;
  logic [SEQ_FIFO_PTR_W-1:0] rp_q, rp_d;
  logic [SEQ_FIFO_CNT_W-1:0] cnt_q, cnt_d;
  logic                      do_pop;
  logic                      do_push;

  // Next-state for storage, pointers and occupancy; push into a full FIFO only with a pop.
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    do_pop  = i_pop && (cnt_q != '0);
    do_push = i_push && ((cnt_q != SEQ_FIFO_CNT_W'(SEQ_FIFO_DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wp_q] = i_data;
      wp_d        = wp_q + SEQ_FIFO_PTR_W'(1);
    end
    if (do_pop) begin
      rp_d = rp_q + SEQ_FIFO_PTR_W'(1);
    end
    cnt_d = cnt_q + SEQ_FIFO_CNT_W'(do_push) - SEQ_FIFO_CNT_W'(do_pop);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SEQ_FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_head  = mem_q[rp_q];
  assign o_count = cnt_q;
  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == SEQ_FIFO_CNT_W'(SEQ_FIFO_DEPTH));

endmodule

// File: rtl/sram_seq_streamer.sv
// Loads a word stream into the sequence SRAM and streams it back with backpressure.
module sram_seq_streamer
  import sram_seq_streamer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start_load,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  input  logic                  i_start_read,
  output logic [WORD_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic                  o_rlast,
  output logic                  o_busy,
  output logic                  o_loaded,
  output logic                  o_CENA,
  output logic                  o_WENA,
  output logic [ADDR_WIDTH-1:0] o_AA,
  output logic [WORD_WIDTH-1:0] o_DA,
  input  logic [WORD_WIDTH-1:0] i_QA
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned OCC_W = SEQ_FIFO_CNT_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(1) << ADDR_WIDTH;

  state_e                    state_q, state_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]          pop_cnt_q, pop_cnt_d;
  logic                      issue_q, issue_d;
  logic                      loaded_q, loaded_d;

  logic [LEN_W-1:0]          len_clamp;
  logic [LEN_W-1:0]          len_m1;
  logic [SEQ_FIFO_CNT_W-1:0] fcnt;
  logic [OCC_W-1:0]          occ;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [WORD_WIDTH-1:0]     fifo_head;
  logic                      can_issue;
  logic                      pop;
  logic                      rlast;

  // Read data lands one cycle after its issue; issue_q marks that cycle.
  seq_stream_fifo #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (issue_q),
    .i_data (i_QA),
    .i_pop  (pop),
    .o_head (fifo_head),
    .o_count(fcnt),
    .o_empty(fifo_empty),
    .o_full (fifo_full)
  );

  // Handshake and flow-control terms shared by the FSM.
  always_comb begin
    len_clamp = (i_len > DEPTH_LEN) ? DEPTH_LEN : i_len;
    len_m1    = len_q - LEN_W'(1);
    occ       = OCC_W'(fcnt) + OCC_W'(issue_q);
    can_issue = (state_q == READ) && (rd_ptr_q < len_q) &&
                (occ < OCC_W'(SEQ_FIFO_DEPTH)) && !fifo_full;
    pop       = !fifo_empty && i_rready;
    rlast     = !fifo_empty && (pop_cnt_q == len_m1);
  end

  // Next-state logic and SRAM port drive; SRAM stays idle unless an access happens this cycle.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pop_cnt_d = pop_cnt_q;
    issue_d   = 1'b0;
    loaded_d  = loaded_q;
    o_wready  = 1'b0;
    o_CENA    = 1'b1;
    o_WENA    = 1'b1;
    o_AA      = '0;
    o_DA      = '0;

    unique case (state_q)
      IDLE: begin
        if (i_start_load && (i_len != '0)) begin
          len_d    = len_clamp;
          wr_ptr_d = '0;
          loaded_d = 1'b0;
          state_d  = LOAD;
        end else if (i_start_read && loaded_q) begin
          rd_ptr_d  = '0;
          pop_cnt_d = '0;
          state_d   = READ;
        end
      end

      LOAD: begin
        o_wready = 1'b1;
        if (i_wvalid) begin
          o_CENA   = 1'b0;
          o_WENA   = 1'b0;
          o_AA     = wr_ptr_q;
          o_DA     = i_wdata;
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          if (LEN_W'(wr_ptr_q) == len_m1) begin
            loaded_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      READ: begin
        if (can_issue) begin
          o_CENA   = 1'b0;
          o_AA     = rd_ptr_q[ADDR_WIDTH-1:0];
          rd_ptr_d = rd_ptr_q + LEN_W'(1);
          issue_d  = 1'b1;
        end
        if (pop) begin
          pop_cnt_d = pop_cnt_q + LEN_W'(1);
          if (rlast) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pop_cnt_q <= '0;
      issue_q   <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pop_cnt_q <= pop_cnt_d;
      issue_q   <= issue_d;
      loaded_q  <= loaded_d;
    end
  end

  assign o_rdata  = fifo_head;
  assign o_rvalid = !fifo_empty;
  assign o_rlast  = rlast;
  assign o_busy   = (state_q != IDLE);
  assign o_loaded = loaded_q;

endmodule

// File: tb/tb_sram_seq_streamer.sv
// Scoreboard bench for sram_seq_streamer with a behavioural single-port SRAM.
module tb_sram_seq_streamer;

  localparam int unsigned WW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  typedef struct {
    logic [WW-1:0] data;
    logic          last;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start_load = 1'b0;
  logic [AW:0]   i_len = '0;
  logic [WW-1:0] i_wdata = '0;
  logic          i_wvalid = 1'b0;
  logic          o_wready;
  logic          i_start_read = 1'b0;
  logic [WW-1:0] o_rdata;
  logic          o_rvalid;
  logic          i_rready = 1'b1;
  logic          o_rlast;
  logic          o_busy;
  logic          o_loaded;
  logic          o_CENA;
  logic          o_WENA;
  logic [AW-1:0] o_AA;
  logic [WW-1:0] o_DA;
  logic [WW-1:0] i_QA;

  logic [WW-1:0] sram [DEPTH];
  logic [WW-1:0] qa_q = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pops_total = 0;
  int pop_cycles[$];
  wr_t wq[$];
  rd_t rq[$];

  logic          stall_prev = 1'b0;
  logic [WW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  sram_seq_streamer #(
    .WORD_WIDTH(WW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start_load(i_start_load),
    .i_len       (i_len),
    .i_wdata     (i_wdata),
    .i_wvalid    (i_wvalid),
    .o_wready    (o_wready),
    .i_start_read(i_start_read),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .i_rready    (i_rready),
    .o_rlast     (o_rlast),
    .o_busy      (o_busy),
    .o_loaded    (o_loaded),
    .o_CENA      (o_CENA),
    .o_WENA      (o_WENA),
    .o_AA        (o_AA),
    .o_DA        (o_DA),
    .i_QA        (i_QA)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: write at the edge, registered read visible the following cycle.
  always @(posedge clk) begin
    if (!o_CENA) begin
      if (!o_WENA) sram[o_AA] <= o_DA;
      else         qa_q <= sram[o_AA];
    end
  end
  assign i_QA = qa_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: checks SRAM writes and readback words against the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (!o_CENA && !o_WENA) begin
        if (wq.size() == 0) begin
          n_checks++;
          $display("FAIL write_unexpected: addr %0h data %0h with no write pending", o_AA, o_DA);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("write_addr", 64'(o_AA), 64'(e.addr));
          chk("write_data", 64'(o_DA), 64'(e.data));
        end
      end
      if (o_rvalid && stall_prev) begin
        chk("stall_data_stable", 64'(o_rdata), 64'(prev_data));
        chk("stall_last_stable", 64'(o_rlast), 64'(prev_last));
      end
      if (o_rvalid && i_rready) begin
        if (rq.size() == 0) begin
          n_checks++;
          $display("FAIL read_unexpected: data %0h with no read pending", o_rdata);
        end else begin
          rd_t r;
          r = rq.pop_front();
          chk("read_data", 64'(o_rdata), 64'(r.data));
          chk("read_last", 64'(o_rlast), 64'(r.last));
        end
        pops_total++;
        pop_cycles.push_back(cyc);
      end
      stall_prev = o_rvalid && !i_rready;
      prev_data  = o_rdata;
      prev_last  = o_rlast;
    end
  end

  task automatic do_load(input int n, input int base, input bit gap, input bit also_read);
    int eff;
    int k;
    int guard;
    bit hs;
    eff = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    for (int j = 0; j < eff; j++) wq.push_back('{addr: AW'(j), data: WW'(base + j)});
    @(posedge clk); #1;
    i_start_load = 1'b1;
    i_len        = (AW+1)'(n);
    i_start_read = also_read;
    @(posedge clk); #1;
    i_start_load = 1'b0;
    i_start_read = 1'b0;
    chk("load_busy", 64'(o_busy), 64'(1));
    chk("load_wready", 64'(o_wready), 64'(1));
    chk("load_loaded_clear", 64'(o_loaded), 64'(0));
    k = 0;
    guard = 0;
    while (k < eff && guard < 400) begin
      i_wvalid = gap ? ((guard % 3) != 1) : 1'b1;
      i_wdata  = WW'(base + k);
      @(negedge clk);
      hs = i_wvalid && o_wready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    i_wvalid = 1'b0;
    chk("load_done_in_time", 64'(guard < 400), 64'(1));
    chk("load_busy_after", 64'(o_busy), 64'(0));
    chk("load_loaded_after", 64'(o_loaded), 64'(1));
  endtask

  task automatic do_read(input int n, input int base, input bit toggle, input bit lat);
    bit pat [4];
    int guard;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int j = 0; j < n; j++) rq.push_back('{data: WW'(base + j), last: (j == n - 1)});
    pop_cycles.delete();
    @(posedge clk); #1;
    i_start_read = 1'b1;
    @(posedge clk); #1;
    i_start_read = 1'b0;
    if (lat) begin
      @(negedge clk); chk("lat_cycle1_rvalid", 64'(o_rvalid), 64'(0));
      chk("lat_cycle1_cena", 64'(o_CENA), 64'(0));
      @(negedge clk); chk("lat_cycle2_rvalid", 64'(o_rvalid), 64'(0));
      @(negedge clk); chk("lat_cycle3_rvalid", 64'(o_rvalid), 64'(1));
    end
    guard = 0;
    while ((rq.size() != 0 || o_busy) && guard < 500) begin
      if (toggle) i_rready = pat[guard % 4];
      @(posedge clk); #1;
      guard++;
    end
    i_rready = 1'b1;
    chk("read_done_in_time", 64'(guard < 500), 64'(1));
    chk("read_busy_after", 64'(o_busy), 64'(0));
    chk("read_loaded_after", 64'(o_loaded), 64'(1));
    if (lat && pop_cycles.size() == n) begin
      chk("read_back_to_back", 64'(pop_cycles[n-1] - pop_cycles[0]), 64'(n - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wready"}, 64'(o_wready), 64'(0));
    chk({tag, "_rvalid"}, 64'(o_rvalid), 64'(0));
    chk({tag, "_rlast"},  64'(o_rlast),  64'(0));
    chk({tag, "_busy"},   64'(o_busy),   64'(0));
    chk({tag, "_loaded"}, 64'(o_loaded), 64'(0));
    chk({tag, "_cena"},   64'(o_CENA),   64'(1));
    chk({tag, "_wena"},   64'(o_WENA),   64'(1));
    chk({tag, "_aa"},     64'(o_AA),     64'(0));
    chk({tag, "_da"},     64'(o_DA),     64'(0));
    chk({tag, "_rdata"},  64'(o_rdata),  64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int guard;

    // Reset values.
    #3;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Read with nothing loaded and a zero-length load are both ignored.
    @(posedge clk); #1; i_start_read = 1'b1;
    @(posedge clk); #1; i_start_read = 1'b0; i_start_load = 1'b1; i_len = '0;
    @(posedge clk); #1; i_start_load = 1'b1; i_start_read = 1'b1;
    @(posedge clk); #1; i_start_load = 1'b0; i_start_read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_busy", 64'(o_busy), 64'(0));
      chk("idle_cena", 64'(o_CENA), 64'(1));
    end

    // Basic load of 5 then full-throughput readback.
    do_load(5, 'hA0, 1'b0, 1'b0);
    do_read(5, 'hA0, 1'b0, 1'b1);

    // Gappy load of 8 and readback under toggling backpressure.
    do_load(8, 'h10, 1'b1, 1'b0);
    do_read(8, 'h10, 1'b1, 1'b0);

    // Oversized length clamps to the full SRAM depth.
    do_load(int'(DEPTH) + 5, 'h100, 1'b0, 1'b0);
    do_read(int'(DEPTH), 'h100, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a readback.
    do_load(8, 'h50, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) rq.push_back('{data: WW'('h50 + j), last: (j == 7)});
    p0 = pops_total;
    @(posedge clk); #1; i_start_read = 1'b1;
    @(posedge clk); #1; i_start_read = 1'b0;
    guard = 0;
    while ((pops_total - p0) < 3 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    chk("rst_mid_reached_3", 64'(pops_total - p0 >= 3), 64'(1));
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    rq.delete();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1; i_start_read = 1'b1;
    @(posedge clk); #1; i_start_read = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_busy", 64'(o_busy), 64'(0));
      chk("post_rst_rvalid", 64'(o_rvalid), 64'(0));
    end

    // Simultaneous starts with a loaded sequence: the load wins.
    do_load(4, 'hB0, 1'b0, 1'b0);
    do_load(3, 'hC0, 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("after_dual_no_rvalid", 64'(o_rvalid), 64'(0));
    end
    do_read(3, 'hC0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    chk("write_queue_drained", 64'(wq.size()), 64'(0));
    chk("read_queue_drained", 64'(rq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
